// File: rtl/wb_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : wb_scoreboard
//  Brief    : Register-file writeback scoreboard. Expected {reg, data} entries
//             are queued in a FIFO and compared in order against the observed
//             register-file writes. Matches, mismatches, unexpected writes,
//             FIFO overflow and stall timeout are tracked, and the run ends
//             in DONE (clean) or FAIL.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_scoreboard #(
    parameter int DATA_W      = 16,
    parameter int REG_W       = 3,
    parameter int DEPTH       = 8,
    parameter int TO_CYC      = 64,
    parameter int STOP_ON_ERR = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     exp_push,
    input  logic [REG_W-1:0]         exp_reg,
    input  logic [DATA_W-1:0]        exp_data,
    input  logic                     start,
    input  logic                     finish,
    input  logic                     wb_valid,
    input  logic [REG_W-1:0]         wb_reg,
    input  logic [DATA_W-1:0]        wb_data,
    output logic                     exp_full,
    output logic [$clog2(DEPTH):0]   pend,
    output logic [7:0]               err_cnt,
    output logic [7:0]               match_cnt,
    output logic                     done,
    output logic                     fail,
    output logic                     timeout,
    output logic                     overflow
);

    localparam int c_PTR_W   = $clog2(DEPTH);
    localparam int c_CNT_W   = c_PTR_W + 1;
    localparam int c_STALL_W = $clog2(TO_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_FAIL = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [REG_W-1:0]       r_fifo_reg  [DEPTH];
    logic [DATA_W-1:0]      r_fifo_data [DEPTH];
    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic [c_PTR_W-1:0]     r_rd_ptr;
    logic [c_CNT_W-1:0]     r_count;
    logic [7:0]             r_err_cnt;
    logic [7:0]             r_match_cnt;
    logic [c_STALL_W-1:0]   r_stall;
    logic                   r_timeout;
    logic                   r_overflow;

    logic                   w_full;
    logic                   w_accepting;
    logic                   w_run;
    logic                   w_push;
    logic                   w_ovf_evt;
    logic                   w_pop;
    logic                   w_match;
    logic                   w_err;
    logic                   w_stall_inc;
    logic                   w_to_hit;
    logic                   w_clean_end;

    // Event decode: what the FIFO and the comparators do this cycle
    always_comb begin
        w_full      = (r_count == c_CNT_W'(DEPTH));
        w_run       = (r_state == S_RUN);
        w_accepting = (r_state == S_IDLE) || w_run;
        w_push      = exp_push && w_accepting && !w_full;
        w_ovf_evt   = exp_push && w_accepting && w_full;
        // A write with nothing queued is always an error (unexpected write)
        w_pop       = w_run && wb_valid && (r_count != '0);
        w_match     = w_pop && (r_fifo_reg[r_rd_ptr] == wb_reg)
                            && (r_fifo_data[r_rd_ptr] == wb_data);
        w_err       = w_run && wb_valid && !w_match;
        w_stall_inc = w_run && (r_count != '0) && !wb_valid;
        w_to_hit    = w_stall_inc && (r_stall == c_STALL_W'(TO_CYC - 1));
        // Errors and overflow raised in the finish cycle itself still count
        w_clean_end = (r_count == '0) && (r_err_cnt == 8'd0) && !w_err
                      && !r_overflow && !w_ovf_evt;
    end

    // Run-control state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Run-control next state; DONE and FAIL are terminal until reset
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_to_hit) begin
                    w_state_next = S_FAIL;
                end else if ((STOP_ON_ERR != 0) && w_err) begin
                    w_state_next = S_FAIL;
                end else if (finish) begin
                    w_state_next = w_clean_end ? S_DONE : S_FAIL;
                end
            end
            default: w_state_next = r_state;
        endcase
    end

    // FIFO storage; contents need no reset because the count gates every read
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_reg[r_wr_ptr]  <= exp_reg;
            r_fifo_data[r_wr_ptr] <= exp_data;
        end
    end

    // Pointers, occupancy, counters and sticky flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_err_cnt   <= 8'd0;
            r_match_cnt <= 8'd0;
            r_stall     <= '0;
            r_timeout   <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_err && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
            if (w_match && (r_match_cnt != 8'hFF)) begin
                r_match_cnt <= r_match_cnt + 8'd1;
            end
            r_stall <= w_stall_inc ? (r_stall + c_STALL_W'(1)) : '0;
            if (w_to_hit) begin
                r_timeout <= 1'b1;
            end
            if (w_ovf_evt) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign exp_full  = w_full;
    assign pend      = r_count;
    assign err_cnt   = r_err_cnt;
    assign match_cnt = r_match_cnt;
    assign done      = (r_state == S_DONE);
    assign fail      = (r_state == S_FAIL);
    assign timeout   = r_timeout;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_wb_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_scoreboard
//  Brief    : Self-checking bench for wb_scoreboard. A queue-based reference
//             model predicts every output after every clock; directed
//             scenarios plus randomized traffic drive the main instance, and a
//             second instance exercises stop-on-first-error.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_scoreboard;

    localparam int DEPTH  = 8;
    localparam int TO_CYC = 64;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;
    localparam int M_FAIL = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance signals
    logic        rst, exp_push, start, finish, wb_valid;
    logic [2:0]  exp_reg, wb_reg;
    logic [15:0] exp_data, wb_data;
    logic        exp_full, done, fail, timeout, overflow;
    logic [3:0]  pend;
    logic [7:0]  err_cnt, match_cnt;

    // Stop-on-error instance signals
    logic        s_rst, s_push, s_start, s_finish, s_wbv;
    logic [2:0]  s_ereg, s_wreg;
    logic [15:0] s_edata, s_wdata;
    logic        s_full, s_done, s_fail, s_timeout, s_overflow;
    logic [3:0]  s_pend;
    logic [7:0]  s_err, s_match;

    wb_scoreboard #(.DATA_W(16), .REG_W(3), .DEPTH(DEPTH), .TO_CYC(TO_CYC), .STOP_ON_ERR(0)) dut (
        .clk(clk), .rst(rst),
        .exp_push(exp_push), .exp_reg(exp_reg), .exp_data(exp_data),
        .start(start), .finish(finish),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
        .exp_full(exp_full), .pend(pend), .err_cnt(err_cnt), .match_cnt(match_cnt),
        .done(done), .fail(fail), .timeout(timeout), .overflow(overflow)
    );

    wb_scoreboard #(.DATA_W(16), .REG_W(3), .DEPTH(DEPTH), .TO_CYC(TO_CYC), .STOP_ON_ERR(1)) dut_soe (
        .clk(clk), .rst(s_rst),
        .exp_push(s_push), .exp_reg(s_ereg), .exp_data(s_edata),
        .start(s_start), .finish(s_finish),
        .wb_valid(s_wbv), .wb_reg(s_wreg), .wb_data(s_wdata),
        .exp_full(s_full), .pend(s_pend), .err_cnt(s_err), .match_cnt(s_match),
        .done(s_done), .fail(s_fail), .timeout(s_timeout), .overflow(s_overflow)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: expected entries as a queue, counters as plain ints
    typedef struct packed {
        logic [2:0]  r;
        logic [15:0] d;
    } ent_t;

    ent_t m_q[$];
    int   m_st, m_err, m_match, m_stall;
    bit   m_to, m_ovf;

    function automatic int sat_inc(input int v);
        return (v < 255) ? v + 1 : 255;
    endfunction

    task automatic model_step();
        int   pre;
        bit   run, act;
        ent_t h;
        if (rst) begin
            m_q.delete();
            m_st = M_IDLE; m_err = 0; m_match = 0; m_stall = 0; m_to = 0; m_ovf = 0;
            return;
        end
        pre = m_q.size();
        run = (m_st == M_RUN);
        act = run || (m_st == M_IDLE);
        if (run && wb_valid) begin
            if (pre > 0) begin
                h = m_q.pop_front();
                if (h.r == wb_reg && h.d == wb_data) m_match = sat_inc(m_match);
                else m_err = sat_inc(m_err);
            end else begin
                m_err = sat_inc(m_err);
            end
        end
        if (act && exp_push) begin
            if (pre == DEPTH) m_ovf = 1;
            else m_q.push_back('{exp_reg, exp_data});
        end
        if (run && pre > 0 && !wb_valid) m_stall++;
        else m_stall = 0;
        if (run) begin
            if (m_stall == TO_CYC) begin
                m_to = 1;
                m_st = M_FAIL;
            end else if (finish) begin
                m_st = (pre == 0 && m_err == 0 && !m_ovf) ? M_DONE : M_FAIL;
            end
        end else if (m_st == M_IDLE && start) begin
            m_st = M_RUN;
        end
    endtask

    // Apply current inputs for one clock, then compare every output to the model
    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_val({tag, ".pend"},     32'(pend),      32'(m_q.size()));
        check_val({tag, ".full"},     32'(exp_full),  32'(m_q.size() == DEPTH));
        check_val({tag, ".err"},      32'(err_cnt),   32'(m_err));
        check_val({tag, ".match"},    32'(match_cnt), 32'(m_match));
        check_val({tag, ".done"},     32'(done),      32'(m_st == M_DONE));
        check_val({tag, ".fail"},     32'(fail),      32'(m_st == M_FAIL));
        check_val({tag, ".timeout"},  32'(timeout),   32'(m_to));
        check_val({tag, ".overflow"}, 32'(overflow),  32'(m_ovf));
        rst = 0; exp_push = 0; start = 0; finish = 0; wb_valid = 0;
    endtask

    task automatic do_rst();
        rst = 1;
        tick("rst");
    endtask

    task automatic do_push(input logic [2:0] r, input logic [15:0] d, input string tag);
        exp_push = 1; exp_reg = r; exp_data = d;
        tick(tag);
    endtask

    task automatic do_wb(input logic [2:0] r, input logic [15:0] d, input string tag);
        wb_valid = 1; wb_reg = r; wb_data = d;
        tick(tag);
    endtask

    task automatic do_start(input string tag);
        start = 1;
        tick(tag);
    endtask

    task automatic do_finish(input string tag);
        finish = 1;
        tick(tag);
    endtask

    // Stop-on-error instance: one clock, sampled after the edge
    task automatic soe_tick();
        @(posedge clk);
        #1;
        s_rst = 0; s_push = 0; s_start = 0; s_finish = 0; s_wbv = 0;
    endtask

    initial begin
        rst = 1; exp_push = 0; start = 0; finish = 0; wb_valid = 0;
        exp_reg = '0; exp_data = '0; wb_reg = '0; wb_data = '0;
        s_rst = 1; s_push = 0; s_start = 0; s_finish = 0; s_wbv = 0;
        s_ereg = '0; s_edata = '0; s_wreg = '0; s_wdata = '0;

        // Reset state of the main instance
        do_rst();
        check_val("reset.pend", 32'(pend), 32'd0);
        check_val("reset.flags", 32'({done, fail, timeout, overflow, exp_full}), 32'd0);

        // Stop-on-first-error instance
        soe_tick();
        s_push = 1; s_ereg = 3'd1; s_edata = 16'h0022;
        soe_tick();
        s_start = 1;
        soe_tick();
        check_val("soe.pend", 32'(s_pend), 32'd1);
        check_val("soe.fail_before", 32'(s_fail), 32'd0);
        s_wbv = 1; s_wreg = 3'd1; s_wdata = 16'h0023;
        soe_tick();
        check_val("soe.fail_next", 32'(s_fail), 32'd1);
        check_val("soe.err", 32'(s_err), 32'd1);
        s_wbv = 1; s_wreg = 3'd1; s_wdata = 16'h0022;
        soe_tick();
        s_wbv = 1;
        soe_tick();
        check_val("soe.err_hold", 32'(s_err), 32'd1);
        check_val("soe.match_hold", 32'(s_match), 32'd0);
        check_val("soe.fail_hold", 32'(s_fail), 32'd1);

        // Three in-order matching writebacks end clean
        do_push(3'd0, 16'h0010, "t33.push0");
        do_push(3'd1, 16'h0001, "t33.push1");
        do_push(3'd2, 16'h0011, "t33.push2");
        do_start("t33.start");
        do_wb(3'd0, 16'h0010, "t33.wb0");
        do_wb(3'd1, 16'h0001, "t33.wb1");
        do_wb(3'd2, 16'h0011, "t33.wb2");
        do_finish("t33.finish");
        check_val("t33.match_cnt", 32'(match_cnt), 32'd3);
        check_val("t33.err_cnt", 32'(err_cnt), 32'd0);
        check_val("t33.done", 32'(done), 32'd1);

        // Data mismatch, then finish -> FAIL
        do_rst();
        do_push(3'd2, 16'h0011, "t34a.push");
        do_start("t34a.start");
        do_wb(3'd2, 16'h0012, "t34a.wb");
        check_val("t34a.err_cnt", 32'(err_cnt), 32'd1);
        do_finish("t34a.finish");
        check_val("t34a.fail", 32'(fail), 32'd1);

        // Register mismatch
        do_rst();
        do_push(3'd2, 16'h0011, "t34b.push");
        do_start("t34b.start");
        do_wb(3'd3, 16'h0011, "t34b.wb");
        check_val("t34b.err_cnt", 32'(err_cnt), 32'd1);

        // Overflow: nine pushes into eight slots
        do_rst();
        for (int i = 0; i < 9; i++) begin
            do_push(3'(i), 16'h0100 + 16'(i), "t35.push");
            if (i == 7) begin
                check_val("t35.full_at8", 32'(exp_full), 32'd1);
                check_val("t35.pend_at8", 32'(pend), 32'd8);
                check_val("t35.ovf_at8", 32'(overflow), 32'd0);
            end
        end
        check_val("t35.overflow", 32'(overflow), 32'd1);
        check_val("t35.pend_after9", 32'(pend), 32'd8);
        do_start("t35.start");
        for (int i = 0; i < 8; i++) begin
            do_wb(3'(i), 16'h0100 + 16'(i), "t35.wb");
        end
        check_val("t35.match_cnt", 32'(match_cnt), 32'd8);
        do_finish("t35.finish");
        check_val("t35.fail", 32'(fail), 32'd1);

        // Stall timeout exactly TO_CYC cycles after start
        do_rst();
        do_push(3'd5, 16'hABCD, "t36.push");
        do_start("t36.start");
        for (int i = 0; i < TO_CYC - 1; i++) begin
            tick("t36.stall");
        end
        check_val("t36.fail_early", 32'(fail), 32'd0);
        check_val("t36.timeout_early", 32'(timeout), 32'd0);
        tick("t36.stall_last");
        check_val("t36.timeout", 32'(timeout), 32'd1);
        check_val("t36.fail", 32'(fail), 32'd1);

        // Same-cycle push and pop keep occupancy; reset then clears everything
        do_rst();
        do_push(3'd1, 16'h0005, "t37.push");
        do_start("t37.start");
        exp_push = 1; exp_reg = 3'd2; exp_data = 16'h0007;
        wb_valid = 1; wb_reg = 3'd1; wb_data = 16'h0005;
        tick("t37.both");
        check_val("t37.pend", 32'(pend), 32'd1);
        check_val("t37.match", 32'(match_cnt), 32'd1);
        do_rst();
        check_val("t37.rst_cnts", 32'({pend, err_cnt, match_cnt}), 32'd0);
        check_val("t37.rst_flags", 32'({done, fail, timeout, overflow, exp_full}), 32'd0);
        do_finish("t37.finish_idle");
        check_val("t37.idle_ignores_finish", 32'({done, fail}), 32'd0);
        do_start("t37.start2");
        do_finish("t37.finish2");
        check_val("t37.done", 32'(done), 32'd1);

        // Unexpected writes saturate the error counter
        do_rst();
        do_start("sat.start");
        for (int i = 0; i < 260; i++) begin
            do_wb(3'(i), 16'(i), "sat.wb");
        end
        check_val("sat.err_cnt", 32'(err_cnt), 32'd255);

        // Randomized traffic against the model
        for (int round = 0; round < 30; round++) begin
            int n;
            do_rst();
            n = $urandom_range(0, 10);
            for (int i = 0; i < n; i++) begin
                do_push(3'($urandom), 16'($urandom), "rnd.preload");
            end
            do_start("rnd.start");
            for (int c = 0; c < 50; c++) begin
                exp_push = ($urandom_range(0, 2) == 0);
                exp_reg  = 3'($urandom);
                exp_data = 16'($urandom);
                wb_valid = ($urandom_range(0, 1) == 0);
                if (m_q.size() > 0 && $urandom_range(0, 4) != 0) begin
                    wb_reg  = m_q[0].r;
                    wb_data = m_q[0].d;
                end else begin
                    wb_reg  = 3'($urandom);
                    wb_data = 16'($urandom);
                end
                finish = ($urandom_range(0, 24) == 0);
                start  = ($urandom_range(0, 19) == 0);
                rst    = ($urandom_range(0, 59) == 0);
                tick("rnd.cycle");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_scoreboard.md
WB_SCOREBOARD -- requirements
Module: wb_scoreboard

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning register write-data width.
REQ-002 The block SHALL have parameter REG_W, default 3, meaning register-select width.
REQ-003 The block SHALL have parameter DEPTH, default 8, meaning expected-entry FIFO depth (power of 2, >=2).
REQ-004 The block SHALL have parameter TO_CYC, default 64, meaning stall cycles tolerated before timeout.
REQ-005 The block SHALL have parameter STOP_ON_ERR, default 0, meaning 1 = enter FAIL on first error.
REQ-006 The block SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-007 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 The block SHALL have ports exp_push (in, 1), exp_reg (in, REG_W) and exp_data (in, DATA_W), the expected-writeback load strobe, register and data.
REQ-009 The block SHALL have ports start (in, 1) and finish (in, 1), the single-cycle run-begin and end-of-program pulses.
REQ-010 The block SHALL have ports wb_valid (in, 1), wb_reg (in, REG_W) and wb_data (in, DATA_W), the DUT register-file write strobe, select (rf_ws) and data (rf_wd).
REQ-011 The block SHALL have outputs exp_full (1) and pend ($clog2(DEPTH)+1), the FIFO-full flag and queued-entry count.
REQ-012 The block SHALL have outputs err_cnt (8) and match_cnt (8), the mismatch and match counts.
REQ-013 The block SHALL have outputs done (1), fail (1), timeout (1) and overflow (1), the state flags, the stall-timeout flag and the push-when-full flag.

Function
REQ-014 The block SHALL implement states IDLE, RUN, DONE and FAIL; done=1 only in DONE and fail=1 only in FAIL.
REQ-015 exp_push with exp_full=0 in IDLE or RUN SHALL enqueue {exp_reg, exp_data}, and pend SHALL increment on the next edge.
REQ-016 exp_push with exp_full=1 SHALL be dropped and SHALL set overflow sticky; exp_push in DONE/FAIL SHALL be ignored.
REQ-017 exp_full SHALL equal (pend==DEPTH); FIFO pointers SHALL wrap modulo DEPTH.
REQ-018 IDLE->RUN SHALL occur on start; start outside IDLE SHALL be ignored.
REQ-019 In RUN with pend>0, wb_valid SHALL pop the head and compare register and data; match increments match_cnt, any field mismatch increments err_cnt.
REQ-020 In RUN with pend==0, wb_valid SHALL count as an unexpected write (err_cnt+1).
REQ-021 Same-cycle push and wb_valid with pend>0 SHALL both take effect, leaving pend unchanged.
REQ-022 Same-cycle push and wb_valid with pend==0 SHALL count the write as unexpected and enqueue the pushed entry (pend=1).
REQ-023 err_cnt and match_cnt SHALL saturate at 255, and compare results SHALL be visible in the counters one cycle after wb_valid.
REQ-024 wb_valid in IDLE, DONE or FAIL SHALL be ignored with no counter change.
REQ-025 A stall counter SHALL count RUN cycles with pend>0 and wb_valid=0 and SHALL clear on wb_valid or pend==0.
REQ-026 When the stall counter reaches TO_CYC, the block SHALL set timeout=1 and go to FAIL.
REQ-027 finish in RUN SHALL go to DONE if pend==0, err_cnt==0 (including an error counted the same cycle) and overflow==0; otherwise it SHALL go to FAIL.
REQ-028 With STOP_ON_ERR=1, the cycle after the first error SHALL be FAIL.
REQ-029 DONE and FAIL SHALL be left only by rst.

Reset
REQ-030 rst SHALL take priority over all inputs, including mid-RUN.
REQ-031 On rst the next edge SHALL give state IDLE, pend=0, pointers=0, err_cnt=0, match_cnt=0, stall counter=0, and done, fail, timeout, overflow and exp_full all 0.
REQ-032 Queued entries SHALL be discarded on rst.

Verification
REQ-033 The bench SHALL cover: push {0,0x0010},{1,0x0001},{2,0x0011}; start; wb (0,0x10),(1,0x01),(2,0x11); finish -> match_cnt=3, err_cnt=0, done=1.
REQ-034 The bench SHALL cover: push {2,0x0011}; start; wb (2,0x0012); finish -> err_cnt=1, fail=1; and wb (3,0x0011) -> err_cnt=1.
REQ-035 The bench SHALL cover: push 9 entries at DEPTH=8 -> exp_full=1 after 8, overflow=1, pend=8; finish after 8 matching writes -> fail=1.
REQ-036 The bench SHALL cover: push 1 entry; start; no wb for TO_CYC cycles -> timeout=1, fail=1 exactly TO_CYC cycles after start.
REQ-037 The bench SHALL cover: pend=1 in RUN; push and matching wb same cycle -> pend stays 1, match_cnt=1; then rst -> all counters 0, state IDLE.
REQ-038 The bench SHALL cover: STOP_ON_ERR=1, one mismatching wb -> fail=1 next cycle; wb_valid ignored afterwards (err_cnt stays 1).
